mac_dot_engine: RTL and testbench

Parametrised multi-lane dot-product accumulator that generalises the single-lane MAC.
- Each accepted beat: N_LANES parallel multiplies feed a registered adder tree into one wide accumulator.
- Vector length is programmed per operation; signed or unsigned mode.
- Handshakes on input and result; the final sum is presented with valid/ready.
- Sits between operand buffers and the result writeback path in the matrix-multiply datapath.

---
 rtl/mac_dot_pkg.sv | 45 ++++
 rtl/mac_lane_tree.sv | 95 +++++++++
 rtl/mac_dot_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_mac_dot_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_dot_pkg.sv
// mac_dot_pkg: shared types and width/bound helpers for the multi-lane dot-product engine.
//   state_e       - engine FSM states
//   len_w/sum_w   - width helpers for the length port and the raw lane-tree sum
//   max_w         - larger of two widths
//   sat_hi/sat_lo - accumulator clamp bounds (BOUND_W-bit two's complement)
package mac_dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned BOUND_W = 64;

    // Bits needed to hold a beat count of 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Full-precision width of the sum of n products of two dw-bit operands.
    function automatic int unsigned sum_w(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int unsigned max_w(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    // Largest representable accumulator value for the selected mode.
    function automatic logic [BOUND_W-1:0] sat_hi(input int unsigned acc_w, input logic sgn);
        logic [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        return sgn ? ((one << (acc_w - 1)) - one) : ((one << acc_w) - one);
    endfunction

    // Smallest representable accumulator value: -2^(acc_w-1) signed, 0 unsigned.
    function automatic logic [BOUND_W-1:0] sat_lo(input int unsigned acc_w, input logic sgn);
        logic [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        return sgn ? ~((one << (acc_w - 1)) - one) : '0;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// mac_lane_tree: N_LANES parallel multipliers (S1 product registers) feeding an
// adder tree whose sign/zero-extended sum is registered in S2.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   i_flush        - synchronous discard of everything in flight
//   i_valid        - operand beat valid (S1 capture enable)
//   i_is_signed    - two's-complement operand interpretation
//   i_a_vec/i_b_vec- packed lane operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_valid        - S2 sum valid
//   o_busy         - any stage holds a valid beat
//   o_sum          - extended tree sum
module mac_lane_tree
    import mac_dot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_LANES    = 4,
    parameter int unsigned TREE_W     = 18
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_flush,
    input  logic                            i_valid,
    input  logic                            i_is_signed,
    input  logic [N_LANES*DATA_WIDTH-1:0]   i_a_vec,
    input  logic [N_LANES*DATA_WIDTH-1:0]   i_b_vec,
    output logic                            o_valid,
    output logic                            o_busy,
    output logic [TREE_W-1:0]               o_sum
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic [PROD_W-1:0] w_prod [N_LANES];
    logic [PROD_W-1:0] r_prod [N_LANES];
    logic [TREE_W-1:0] w_tree;
    logic [TREE_W-1:0] r_sum;
    logic              r_v1;
    logic              r_v2;

    // Per-lane multiply: operands are pre-extended to product width, so the low
    // PROD_W bits of one unsigned multiplier are correct in both modes.
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_a;
        logic [DATA_WIDTH-1:0] w_b;
        logic [PROD_W-1:0]     w_ax;
        logic [PROD_W-1:0]     w_bx;

        assign w_a  = i_a_vec[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_b  = i_b_vec[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_ax = {{DATA_WIDTH{w_a[DATA_WIDTH-1] & i_is_signed}}, w_a};
        assign w_bx = {{DATA_WIDTH{w_b[DATA_WIDTH-1] & i_is_signed}}, w_b};
        assign w_prod[gi] = w_ax * w_bx;
    end

    // Adder tree over the registered products, extended per mode.
    always_comb begin : tree_sum
        w_tree = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (i_is_signed) begin
                w_tree = w_tree + TREE_W'($signed(r_prod[i]));
            end else begin
                w_tree = w_tree + TREE_W'(r_prod[i]);
            end
        end
    end

    // S1/S2 registers; data only moves with a valid beat so bubbles carry nothing.
    always_ff @(posedge clk or negedge rst_n) begin : stage_regs
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_sum <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else if (i_flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            if (i_valid) begin
                r_prod <= w_prod;
            end
            if (r_v1) begin
                r_sum <= w_tree;
            end
        end
    end

    assign o_valid = r_v2;
    assign o_busy  = r_v1 | r_v2;
    assign o_sum   = r_sum;

endmodule

// File: rtl/mac_dot_engine.sv
// mac_dot_engine: multi-lane dot-product accumulator. Each accepted beat multiplies
// N_LANES operand pairs, sums them in mac_lane_tree and adds the sum into a wide
// accumulator; after len beats the result is offered with out_valid/out_ready.
// Build option: define MAC_DOT_SAT_EN for a saturating accumulator with sticky ovf;
// otherwise the accumulator wraps modulo 2^ACC_W and ovf stays 0.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   clr                 - synchronous abort to IDLE, flushes pipeline and accumulator
//   start/len/is_signed - operation launch (IDLE only), length and mode latched
//   in_valid/in_ready   - operand beat handshake, a_vec/b_vec packed per lane
//   out_valid/out_ready - result handshake, result = accumulator
//   ovf                 - saturation occurred during this operation
//   busy                - engine not in IDLE
module mac_dot_engine
    import mac_dot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_LANES    = 4,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned ACC_W      = 2 * DATA_WIDTH + $clog2(N_LANES) + $clog2(MAX_LEN)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            start,
    input  logic [len_w(MAX_LEN)-1:0]       len,
    input  logic                            is_signed,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_LANES*DATA_WIDTH-1:0]   a_vec,
    input  logic [N_LANES*DATA_WIDTH-1:0]   b_vec,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_W-1:0]                result,
    output logic                            ovf,
    output logic                            busy
);

    localparam int unsigned LEN_W  = len_w(MAX_LEN);
    // Tree sum is kept at full precision even when ACC_W is narrower, so that
    // saturation sees the true magnitude; two guard bits keep S3 overflow-free.
    localparam int unsigned TREE_W = max_w(ACC_W, sum_w(DATA_WIDTH, N_LANES));
    localparam int unsigned S3_W   = TREE_W + 2;

    state_e             r_state;
    state_e             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_signed;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_v3;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_in_ready_d;
    logic               w_out_valid_d;
    logic               w_busy_d;
    logic               w_start;
    logic               w_accept;
    logic               w_last;
    logic               w_tree_valid;
    logic               w_tree_busy;
    logic [TREE_W-1:0]  w_tree_sum;
    logic [S3_W-1:0]    w_acc_ext;
    logic [S3_W-1:0]    w_tree_ext;
    logic [S3_W-1:0]    w_sum3;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_clamp;

    assign w_start  = (r_state == IDLE) && start && (len != '0);
    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_cnt == LEN_W'(r_len - LEN_W'(1)));

    mac_lane_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_LANES    (N_LANES),
        .TREE_W     (TREE_W)
    ) u_tree (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (clr),
        .i_valid     (w_accept),
        .i_is_signed (r_signed),
        .i_a_vec     (a_vec),
        .i_b_vec     (b_vec),
        .o_valid     (w_tree_valid),
        .o_busy      (w_tree_busy),
        .o_sum       (w_tree_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; clr overrides everything.
    always_comb begin : next_state
        w_next = r_state;
        if (clr) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start)                     w_next = RUN;
                RUN:     if (w_accept && w_last)          w_next = DRAIN;
                DRAIN:   if (!w_tree_busy && !r_v3)       w_next = DONE;
                DONE:    if (out_ready)                   w_next = IDLE;
                default:                                  w_next = IDLE;
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs track the state.
    always_comb begin : out_decode
        w_in_ready_d  = 1'b0;
        w_out_valid_d = 1'b0;
        w_busy_d      = 1'b0;
        case (w_next)
            RUN: begin
                w_in_ready_d = 1'b1;
                w_busy_d     = 1'b1;
            end
            DRAIN: begin
                w_busy_d = 1'b1;
            end
            DONE: begin
                w_out_valid_d = 1'b1;
                w_busy_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : out_regs
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
            r_busy      <= w_busy_d;
        end
    end

    // S3 adder: both operands extended per mode into a width that cannot overflow.
    always_comb begin : s3_add
        if (r_signed) begin
            w_acc_ext  = S3_W'($signed(r_acc));
            w_tree_ext = S3_W'($signed(w_tree_sum));
        end else begin
            w_acc_ext  = S3_W'(r_acc);
            w_tree_ext = S3_W'(w_tree_sum);
        end
        w_sum3 = w_acc_ext + w_tree_ext;
    end

`ifdef MAC_DOT_SAT_EN
    logic [S3_W-1:0] w_hi;
    logic [S3_W-1:0] w_lo;

    // Clamp to the representable range of the current mode.
    always_comb begin : s3_sat
        w_hi      = S3_W'(sat_hi(ACC_W, r_signed));
        w_lo      = S3_W'(sat_lo(ACC_W, r_signed));
        w_clamp   = 1'b0;
        w_acc_nxt = ACC_W'(w_sum3);
        if ($signed(w_sum3) > $signed(w_hi)) begin
            w_acc_nxt = ACC_W'(w_hi);
            w_clamp   = 1'b1;
        end else if ($signed(w_sum3) < $signed(w_lo)) begin
            w_acc_nxt = ACC_W'(w_lo);
            w_clamp   = 1'b1;
        end
    end
`else
    // Modulo 2^ACC_W wrap in both modes.
    assign w_acc_nxt = ACC_W'(w_sum3);
    assign w_clamp   = 1'b0;
`endif

    // Operation context, beat counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin : acc_regs
        if (!rst_n) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_v3     <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_v3  <= 1'b0;
        end else begin
            r_v3 <= w_tree_valid;
            if (w_start) begin
                r_len    <= len;
                r_signed <= is_signed;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_ovf    <= 1'b0;
            end
            if (w_accept) begin
                r_cnt <= LEN_W'(r_cnt + LEN_W'(1));
            end
            if (w_tree_valid) begin
                r_acc <= w_acc_nxt;
                if (w_clamp) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_acc;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_mac_dot_engine.sv
// tb_mac_dot_engine: drives two engines (ACC_W=22 default and ACC_W=16) with the
// same operand stream and compares both against an integer dot-product model.
module tb_mac_dot_engine;

    localparam int unsigned DW  = 8;
    localparam int unsigned NL  = 4;
    localparam int unsigned ML  = 16;
    localparam int unsigned LW  = 5;
    localparam int unsigned AW0 = 22;
    localparam int unsigned AW1 = 16;
    localparam int unsigned VW  = NL * DW;
`ifdef MAC_DOT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr = 1'b0;
    logic start = 1'b0;
    logic is_signed = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [LW-1:0] len = '0;
    logic [VW-1:0] a_vec = '0;
    logic [VW-1:0] b_vec = '0;

    logic in_ready0, out_valid0, ovf0, busy0;
    logic in_ready1, out_valid1, ovf1, busy1;
    logic [AW0-1:0] result0;
    logic [AW1-1:0] result1;

    int n_checks = 0;
    int n_errors = 0;
    logic [VW-1:0] av [ML];
    logic [VW-1:0] bv [ML];

    always #5 clk = ~clk;

    mac_dot_engine #(.DATA_WIDTH(DW), .N_LANES(NL), .MAX_LEN(ML), .ACC_W(AW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len),
        .is_signed(is_signed), .in_valid(in_valid), .in_ready(in_ready0),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .ovf(ovf0), .busy(busy0)
    );

    mac_dot_engine #(.DATA_WIDTH(DW), .N_LANES(NL), .MAX_LEN(ML), .ACC_W(AW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len),
        .is_signed(is_signed), .in_valid(in_valid), .in_ready(in_ready1),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .ovf(ovf1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Dot product of the first n beats of av/bv in plain integers, then reduced to
    // a w-bit accumulator (wrap or clamp). Returns {ovf, w-bit result}.
    function automatic logic [64:0] model(input int n, input bit sgn, input int w);
        longint acc, s, x, y, m, hi, lo;
        bit ov;
        acc = 0;
        ov  = 1'b0;
        m   = longint'(1) << w;
        hi  = sgn ? (m / 2) - 1 : m - 1;
        lo  = sgn ? -(m / 2) : 0;
        for (int b = 0; b < n; b++) begin
            s = 0;
            for (int l = 0; l < NL; l++) begin
                x = longint'(av[b][l*DW +: DW]);
                y = longint'(bv[b][l*DW +: DW]);
                if (sgn && x >= 128) x = x - 256;
                if (sgn && y >= 128) y = y - 256;
                s = s + x * y;
            end
            acc = acc + s;
            if (SAT) begin
                if (acc > hi) begin
                    acc = hi;
                    ov  = 1'b1;
                end else if (acc < lo) begin
                    acc = lo;
                    ov  = 1'b1;
                end
            end else begin
                acc = acc & (m - 1);
            end
        end
        return {ov, 64'(acc & (m - 1))};
    endfunction

    // One complete operation over av/bv[0..n-1] with random input gaps and a
    // held-off out_ready, checking latency, hold behaviour and final values.
    task automatic run_op(input int n, input bit sgn, input int gap_max, input int rdly,
                          input bit start_in_run);
        logic [64:0] e0, e1;
        int lat;
        int g;
        e0 = model(n, sgn, AW0);
        e1 = model(n, sgn, AW1);
        @(negedge clk);
        start = 1'b1;
        len = LW'(n);
        is_signed = sgn;
        @(negedge clk);
        start = 1'b0;
        check("in_ready_run", {61'd0, in_ready0, busy0, in_ready1}, 64'd7);
        for (int b = 0; b < n; b++) begin
            in_valid = 1'b0;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            a_vec = av[b];
            b_vec = bv[b];
            if (start_in_run && b == 0) begin
                start = 1'b1;
                len = LW'(1);
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        check("in_ready_drop", {63'd0, in_ready0}, 64'd0);
        lat = 1;
        while (!out_valid0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat - 1), 64'd4);
        repeat (rdly) begin
            @(negedge clk);
            check("done_hold", {40'd0, out_valid0, in_ready0, result0}, {40'd0, 1'b1, 1'b0, e0[AW0-1:0]});
        end
        check("result0", 64'(result0), 64'(e0[AW0-1:0]));
        check("result1", 64'(result1), 64'(e1[AW1-1:0]));
        check("ovf", {62'd0, ovf0, ovf1}, {62'd0, e0[64], e1[64]});
        check("out_valid1", {63'd0, out_valid1}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handshake", {60'd0, out_valid0, busy0, out_valid1, busy1}, 64'd0);
    endtask

    task automatic watch_no_valid(input string tag);
        int seen;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #2 rst_n = 1'b0;
        #2;
        check("reset_outs", {37'd0, busy0, in_ready0, out_valid0, ovf0, result0},
              64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: 1*5+2*6+3*7+4*8 = 70 per beat, two beats back-to-back -> 140.
        av[0] = 32'h04030201; bv[0] = 32'h08070605;
        av[1] = 32'h04030201; bv[1] = 32'h08070605;
        run_op(2, 1'b0, 0, 0, 1'b0);

        // Signed full length: (-128)*(-128)*4*16 = 1048576, then b=127 -> -1040384.
        for (int i = 0; i < ML; i++) begin
            av[i] = 32'h80808080;
            bv[i] = 32'h80808080;
        end
        run_op(ML, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < ML; i++) bv[i] = 32'h7f7f7f7f;
        run_op(ML, 1'b1, 0, 0, 1'b0);

        // Unsigned 255*255*4 = 260100: fits ACC_W=22, wraps/clamps at ACC_W=16.
        av[0] = 32'hffffffff; bv[0] = 32'hffffffff;
        run_op(1, 1'b0, 0, 0, 1'b0);

        // Backpressure: input gaps 0-3, out_ready held low 5 cycles.
        for (int i = 0; i < 6; i++) begin
            av[i] = $urandom;
            bv[i] = $urandom;
        end
        run_op(6, 1'b1, 3, 5, 1'b0);

        // start asserted during RUN with a different len is ignored.
        for (int i = 0; i < 4; i++) begin
            av[i] = $urandom;
            bv[i] = $urandom;
        end
        run_op(4, 1'b0, 1, 1, 1'b1);

        // start with len=0 stays in IDLE.
        @(negedge clk);
        start = 1'b1;
        len = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("len0_idle", {62'd0, busy0, in_ready0}, 64'd0);

        // clr in RUN after 1 of 4 beats.
        @(negedge clk);
        start = 1'b1; len = LW'(4); is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a_vec = 32'h11223344; b_vec = 32'h55667788;
        @(negedge clk);
        in_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_run", {39'd0, busy0, in_ready0, out_valid0, result0}, 64'd0);
        watch_no_valid("clr_run_no_valid");

        // clr in DRAIN once the accumulator holds a value.
        @(negedge clk);
        start = 1'b1; len = LW'(1); is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a_vec = 32'hffffffff; b_vec = 32'hffffffff;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_drain", {37'd0, busy0, in_ready0, out_valid0, ovf1, result0}, 64'd0);
        watch_no_valid("clr_drain_no_valid");

        // Clean op after aborts: 1*2*4 = 8.
        av[0] = 32'h01010101; bv[0] = 32'h02020202;
        run_op(1, 1'b0, 0, 0, 1'b0);

        // Asynchronous reset mid-RUN with a non-zero accumulator.
        @(negedge clk);
        start = 1'b1; len = LW'(4); is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a_vec = 32'hffffffff; b_vec = 32'hffffffff;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async0", {37'd0, busy0, in_ready0, out_valid0, ovf0, result0}, 64'd0);
        check("rst_async1", {43'd0, busy1, in_ready1, out_valid1, ovf1, result1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random operations.
        for (int t = 0; t < 10; t++) begin
            int n;
            n = int'($urandom_range(ML, 1));
            for (int i = 0; i < n; i++) begin
                av[i] = $urandom;
                bv[i] = $urandom;
            end
            run_op(n, 1'($urandom_range(1, 0)), 3, int'($urandom_range(5, 0)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
